// File: rtl/demux_pkg.sv
// Shared constants and helpers for the 1-to-LANES serial deserialising demux.
package demux_pkg;

  localparam int unsigned DEF_LANES = 4;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned SEL_MAX   = 32;

  // True only when exactly one bit of the (zero-extended) select is set.
  function automatic logic is_onehot(input logic [SEL_MAX-1:0] sel);
    return (sel != '0) && ((sel & (sel - SEL_MAX'(1))) == '0);
  endfunction

endpackage

// File: rtl/demux_1x4_deser_if.sv
// Serial input and per-lane word output bundle of the deserialising demux.
interface demux_1x4_deser_if
  import demux_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic                   bit_i;
  logic                   valid_i;
  logic [LANES-1:0]       sel_i;
  logic                   ready_o;
  logic [LANES*WIDTH-1:0] lane_data_o;
  logic [LANES-1:0]       lane_valid_o;
  logic [LANES-1:0]       lane_ready_i;
  logic                   sel_err_o;

  modport master (
    output bit_i, valid_i, sel_i, lane_ready_i,
    input  ready_o, lane_data_o, lane_valid_o, sel_err_o
  );

  modport slave (
    input  bit_i, valid_i, sel_i, lane_ready_i,
    output ready_o, lane_data_o, lane_valid_o, sel_err_o
  );

endinterface

// File: rtl/demux_lane.sv
// One output lane: LSB-first shift register, bit counter and a single-word holding register.
module demux_lane
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             bit_i,
  input  logic             push_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             can_push_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;

  assign shifted    = {bit_i, shreg_q[WIDTH-1:1]};
  assign last_bit   = (count_q == LAST);
  // Only a completing bit into a full, undrained holding register must wait.
  assign can_push_o = !(last_bit && hold_valid_q && !ready_i);

  always_comb begin
    count_d      = count_q;
    shreg_d      = shreg_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (hold_valid_q && ready_i) begin
      hold_valid_d = 1'b0;
    end
    if (push_i) begin
      shreg_d = shifted;
      if (last_bit) begin
        hold_d       = shifted;
        hold_valid_d = 1'b1;
        count_d      = '0;
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q      <= '0;
      shreg_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      shreg_q      <= shreg_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign data_o  = hold_q;
  assign valid_o = hold_valid_q;

endmodule

// File: rtl/demux_1x4_deser.sv
// Routes a serial bit stream to one of LANES word assemblers chosen by a one-hot select.
module demux_1x4_deser
  import demux_pkg::*;
#(
  parameter int unsigned LANES = DEF_LANES,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  demux_1x4_deser_if.slave     bus
);

  logic             sel_legal;
  logic [LANES-1:0] can_push;
  logic [LANES-1:0] push;
  logic             sel_err_q, sel_err_d;

  assign sel_legal = is_onehot(SEL_MAX'(bus.sel_i));

  // Illegal selects are swallowed: ready stays high but no lane is pushed.
  assign push        = (bus.valid_i && sel_legal) ? (bus.sel_i & can_push) : '0;
  assign bus.ready_o = !sel_legal || ((bus.sel_i & can_push) != '0);

  assign sel_err_d = bus.valid_i && !sel_legal;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign bus.sel_err_o = sel_err_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    demux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .bit_i      (bus.bit_i),
      .push_i     (push[k]),
      .data_o     (bus.lane_data_o[k*WIDTH +: WIDTH]),
      .valid_o    (bus.lane_valid_o[k]),
      .ready_i    (bus.lane_ready_i[k]),
      .can_push_o (can_push[k])
    );
  end

endmodule

// File: tb/tb_demux_1x4_deser.sv
// Directed and random checks of demux_1x4_deser against a word-level reference model.
module tb_demux_1x4_deser;

  localparam int L = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  demux_1x4_deser_if #(.LANES(L), .WIDTH(W)) bus ();

  demux_1x4_deser #(.LANES(L), .WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bits collected per lane, completed word, pending flag.
  int         mcnt [L];
  int         macc [L];
  logic [7:0] mhold[L];
  logic       mhv  [L];
  logic       merr;

  logic r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [L-1:0] s);
    int n = 0;
    int idx = -1;
    for (int k = 0; k < L; k++) if (s[k]) begin n++; idx = k; end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic logic exp_ready(input logic [L-1:0] s, input logic [L-1:0] lr);
    int idx = onehot_idx(s);
    if (idx < 0) return 1'b1;
    return !(mcnt[idx] == W - 1 && mhv[idx] && !lr[idx]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < L; k++) begin
      mcnt[k] = 0; macc[k] = 0; mhold[k] = 8'h00; mhv[k] = 1'b0;
    end
    merr = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    for (int k = 0; k < L; k++) begin
      chk($sformatf("%s.valid%0d", tag, k), 32'(bus.lane_valid_o[k]), 32'(mhv[k]));
      if (mhv[k])
        chk($sformatf("%s.data%0d", tag, k), 32'(bus.lane_data_o[k*W +: W]), 32'(mhold[k]));
    end
    chk({tag, ".sel_err"}, 32'(bus.sel_err_o), 32'(merr));
  endtask

  // One cycle: drive, check ready_o, clock, advance the model, check registered outputs.
  task automatic step(input logic b, input logic v, input logic [L-1:0] s,
                      input logic [L-1:0] lr, input string tag, output logic rdy);
    logic er;
    int   idx;
    bus.bit_i = b; bus.valid_i = v; bus.sel_i = s; bus.lane_ready_i = lr;
    #1;
    er  = exp_ready(s, lr);
    rdy = bus.ready_o;
    chk({tag, ".ready"}, 32'(rdy), 32'(er));
    @(posedge clk);
    idx = onehot_idx(s);
    for (int k = 0; k < L; k++) if (mhv[k] && lr[k]) mhv[k] = 1'b0;
    if (v && er && idx >= 0) begin
      macc[idx] = macc[idx] | (int'(b) << mcnt[idx]);
      mcnt[idx]++;
      if (mcnt[idx] == W) begin
        mhold[idx] = 8'(macc[idx]);
        mhv[idx]   = 1'b1;
        mcnt[idx]  = 0;
        macc[idx]  = 0;
      end
    end
    merr = v && (idx < 0);
    #1;
    check_outputs(tag);
  endtask

  task automatic send_bits(input int k, input logic [7:0] word, input int lo, input int hi,
                           input logic [L-1:0] lr, input string tag);
    logic rdy;
    int   tries;
    for (int i = lo; i <= hi; i++) begin
      tries = 0;
      do begin
        step(word[i], 1'b1, L'(1 << k), lr, tag, rdy);
        tries++;
      end while (!rdy && tries < 16);
      checks++;
      assert (rdy === 1'b1) else begin
        errors++;
        $error("FAIL %s.timeout: observed ready %0b expected 1", tag, rdy);
      end
    end
  endtask

  task automatic idle(input logic [L-1:0] lr, input string tag);
    logic rdy;
    step(1'b0, 1'b0, '0, lr, tag, rdy);
  endtask

  initial begin
    bus.bit_i = 1'b0; bus.valid_i = 1'b0; bus.sel_i = '0; bus.lane_ready_i = '0;
    model_reset();
    #1;
    chk("reset.valid", 32'(bus.lane_valid_o), 32'h0);
    chk("reset.data", 32'(bus.lane_data_o), 32'h0);
    chk("reset.sel_err", 32'(bus.sel_err_o), 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // Single word into lane 0: bits 1,0,1,0,0,1,0,1
    send_bits(0, 8'hA5, 0, 7, 4'b0000, "t1");
    chk("t1.valid_vec", 32'(bus.lane_valid_o), 32'h1);
    chk("t1.word", 32'(bus.lane_data_o[7:0]), 32'hA5);
    idle(4'b0001, "t1.drain");

    // Back-pressure on lane 2
    send_bits(2, 8'h3C, 0, 7, 4'b0000, "t2.load");
    send_bits(2, 8'hFF, 0, 6, 4'b0000, "t2.seven");
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 4'b0100, 4'b0000, "t2.stall", r);
      chk("t2.stall_ready", 32'(r), 32'h0);
      chk("t2.stall_word", 32'(bus.lane_data_o[23:16]), 32'h3C);
    end
    step(1'b1, 1'b1, 4'b0100, 4'b0100, "t2.release", r);
    chk("t2.release_ready", 32'(r), 32'h1);
    chk("t2.new_valid", 32'(bus.lane_valid_o[2]), 32'h1);
    chk("t2.new_word", 32'(bus.lane_data_o[23:16]), 32'hFF);
    idle(4'b0100, "t2.drain");

    // Interleave lanes 1 and 3
    for (int i = 0; i < W; i++) begin
      logic [7:0] w1, w3;
      w1 = 8'h0F; w3 = 8'hF0;
      step(w1[i], 1'b1, 4'b0010, 4'b0000, "t3.l1", r);
      if (i == W - 1) begin
        chk("t3.l1_valid", 32'(bus.lane_valid_o[1]), 32'h1);
        chk("t3.l3_not_yet", 32'(bus.lane_valid_o[3]), 32'h0);
        chk("t3.l1_word", 32'(bus.lane_data_o[15:8]), 32'h0F);
      end
      step(w3[i], 1'b1, 4'b1000, 4'b0000, "t3.l3", r);
    end
    chk("t3.l3_valid", 32'(bus.lane_valid_o[3]), 32'h1);
    chk("t3.l3_word", 32'(bus.lane_data_o[31:24]), 32'hF0);
    idle(4'b1010, "t3.drain");

    // Illegal selects in the middle of a lane-1 word
    send_bits(1, 8'h5A, 0, 2, 4'b0000, "t4.pre");
    step(1'b0, 1'b1, 4'b0110, 4'b0000, "t4.multi", r);
    chk("t4.multi_ready", 32'(r), 32'h1);
    chk("t4.multi_err", 32'(bus.sel_err_o), 32'h1);
    step(1'b1, 1'b1, 4'b0000, 4'b0000, "t4.zero", r);
    chk("t4.zero_ready", 32'(r), 32'h1);
    chk("t4.zero_err", 32'(bus.sel_err_o), 32'h1);
    step(1'b1, 1'b0, 4'b0000, 4'b0000, "t4.novalid", r);
    chk("t4.novalid_err", 32'(bus.sel_err_o), 32'h0);
    send_bits(1, 8'h5A, 3, 7, 4'b0000, "t4.post");
    chk("t4.word", 32'(bus.lane_data_o[15:8]), 32'h5A);
    idle(4'b0010, "t4.drain");

    // Asynchronous reset mid-word, with a held word and a pending error
    send_bits(3, 8'hC3, 0, 7, 4'b0000, "t5.hold");
    send_bits(0, 8'hFF, 0, 4, 4'b0000, "t5.partial");
    step(1'b0, 1'b1, 4'b0011, 4'b0000, "t5.err", r);
    #3; rst = 1'b1; #1;
    model_reset();
    chk("t5.rst_valid", 32'(bus.lane_valid_o), 32'h0);
    chk("t5.rst_data", 32'(bus.lane_data_o), 32'h0);
    chk("t5.rst_err", 32'(bus.sel_err_o), 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    send_bits(0, 8'h81, 0, 7, 4'b0000, "t5.after");
    chk("t5.word", 32'(bus.lane_data_o[7:0]), 32'h81);
    idle(4'b0001, "t5.drain");

    // Drain and fill lane 0 in the same cycle
    send_bits(0, 8'h11, 0, 7, 4'b0000, "t6.first");
    send_bits(0, 8'h22, 0, 6, 4'b0000, "t6.fill");
    step(1'b0, 1'b1, 4'b0001, 4'b0001, "t6.swap", r);
    chk("t6.swap_ready", 32'(r), 32'h1);
    chk("t6.valid", 32'(bus.lane_valid_o[0]), 32'h1);
    chk("t6.word", 32'(bus.lane_data_o[7:0]), 32'h22);
    idle(4'b0001, "t6.drain");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [L-1:0] s, lr;
      logic         v, b;
      v  = ($urandom_range(0, 3) != 0);
      b  = 1'($urandom_range(0, 1));
      s  = ($urandom_range(0, 7) == 0) ? L'($urandom_range(0, 15)) : L'(1 << $urandom_range(0, 3));
      lr = L'($urandom_range(0, 15));
      step(b, v, s, lr, "rnd", r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1x4_deser.md
Name: demux_1x4_deser

Overview:
Serial-to-parallel 1-to-LANES demultiplexer. It is the inverse of the team's one-hot-select N:1 mux.
- A single-bit input stream is routed, bit by bit, to the lane chosen by a one-hot select.
- Each lane assembles WIDTH bits into a word and presents it on a valid/ready output handshake.
- It sits between a serial front-end and LANES parallel word consumers.

Parameters:
LANES, 4, number of output lanes; width of the one-hot select.
WIDTH, 8, bits per assembled word.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset, asynchronous, active-high.
bit_i  in  1  serial data bit.
valid_i  in  1  bit_i is valid this cycle.
sel_i  in  LANES  one-hot lane select, sampled with valid_i.
ready_o  out  1  demux accepts bit_i this cycle (combinational).
lane_data_o  out  LANES*WIDTH  lane k word on bits [k*WIDTH +: WIDTH].
lane_valid_o  out  LANES  lane k word is held and valid.
lane_ready_i  in  LANES  consumer k takes the word this cycle.
sel_err_o  out  1  one-cycle pulse: an illegal select was seen with valid_i.

Behaviour:
Reset:
- rst_i high immediately clears every lane's shift register, bit counter and holding register.
- lane_valid_o, lane_data_o and sel_err_o read 0 while rst_i is high.
- Reset mid-word discards all partial bits; there is no carry-over after release.

Accept:
- A bit is accepted when valid_i && ready_o.
- Legal sel_i means exactly one bit set.

Per-lane state (count 0..WIDTH-1, shift register, holding register, hold_valid):
- On an accepted bit: shreg <= {bit_i, shreg[WIDTH-1:1]} (LSB-first), and count increments.
- When the accepted bit is the WIDTH-th (count == WIDTH-1):
  - {bit_i, shreg[WIDTH-1:1]} is loaded into the holding register.
  - hold_valid is set.
  - count wraps to 0.
- Latency: lane_valid_o[k] rises on the clock edge that accepts the WIDTH-th bit, i.e. it is visible the cycle after that bit is presented.

Output handshake:
- A word transfers when lane_valid_o[k] && lane_ready_i[k]; hold_valid then clears.
- lane_data_o stays stable while valid and not ready.

ready_o rules:
- Legal sel_i selecting lane k: ready_o = 0 only when count_k == WIDTH-1 && hold_valid_k && !lane_ready_i[k]. Otherwise ready_o = 1.
- Simultaneous drain and fill in the same cycle is allowed; lane_valid_o stays 1 with the new word and there is no bubble.
- Illegal sel_i (zero-hot or multi-hot): ready_o = 1, the bit is discarded, and no lane state changes.
- When valid_i is high, sel_err_o is registered high for exactly one cycle after the illegal sel_i. When valid_i is low, sel_i is ignored and sel_err_o stays 0.

Lane independence:
- Interleaved bits to different lanes accumulate independently.
- Back-pressure on one lane never stalls bits addressed to another lane.

Decomposition:
- Package demux_pkg: default LANES/WIDTH constants and a function is_onehot(sel) returning 1 only for exactly one bit set.
- Sub-module demux_lane (ports clk_i, rst_i, bit_i, push_i, data_o, valid_o, ready_i, can_push_o), instantiated LANES times in a generate loop.
- The top holds only the one-hot decode, the ready_o mux and the sel_err_o register.

Test Plan:
1. Single word:
   - Stimulus: sel_i=0001; bits 1,0,1,0,0,1,0,1 on consecutive cycles; lane_ready_i=0.
   - Required: lane_valid_o=0001 after the 8th edge; lane_data_o[7:0]=8'hA5; other lanes valid 0.
2. Back-pressure:
   - Stimulus: lane 2 holds 8'h3C with lane_ready_i[2]=0; 8 bits of 1 sent to sel_i=0100.
   - Required: first 7 bits accepted. On the 8th bit ready_o=0 until lane_ready_i[2]=1. In that cycle ready_o=1, 8'h3C transfers, and 8'hFF is held next cycle with lane_valid_o[2] continuously 1.
3. Interleave:
   - Stimulus: alternate bits to sel_i=0010 (word 8'h0F) and 1000 (word 8'hF0), lane 1 first, 16 cycles.
   - Required: lane_valid_o[1] rises after cycle 15 with 8'h0F. lane_valid_o[3] rises one cycle later with 8'hF0.
4. Illegal select:
   - Stimulus: valid_i=1, sel_i=0110, then sel_i=0000.
   - Required: ready_o=1 in both cycles; sel_err_o=1 on each following cycle; no lane count or data changes.
   - Stimulus: valid_i=0, sel_i=0000.
   - Required: sel_err_o stays 0.
5. Reset mid-word:
   - Stimulus: 5 bits to lane 0, then assert rst_i asynchronously between edges.
   - Required: outputs 0 immediately.
   - Stimulus: after release, send 8'h81.
   - Required: lane_data_o[7:0]=8'h81 exactly, with no stale bits.
6. Drain/fill same cycle:
   - Stimulus: lane 0 holds 8'h11; the 8th bit of 8'h22 arrives with lane_ready_i[0]=1.
   - Required: next cycle lane_data_o[7:0]=8'h22; lane_valid_o[0] never deasserts.
